// File: rtl/ed25519_in_unpack.sv
// ---------------------------------------------------------------------------
// ed25519_in_unpack
//
// Collects a stream of DATA_W-bit beats into one ed25519 job: scalar k and
// base point (x, y), each PATN_W bits. Every operand is sent most-significant
// word first, in the order scalar, x, y. When the last beat arrives the
// packet is held stable towards the core until it is accepted.
//
// The module also flags whether x and y are non-canonical field elements,
// meaning the value is >= p, where p = 2^255 - 19.
//
// Ports
//   i_clk        in   1       clock, rising edge
//   i_rst_n      in   1       asynchronous active-low reset
//   i_in_valid   in   1       upstream beat valid
//   o_in_ready   out  1       beat can be accepted (COLLECT and out of reset)
//   i_in_data    in   DATA_W  input beat
//   o_pkt_valid  out  1       assembled packet valid (HOLD)
//   i_pkt_ready  in   1       core accepts packet
//   o_scalar     out  PATN_W  scalar k
//   o_px         out  PATN_W  base point x
//   o_py         out  PATN_W  base point y
//   o_x_ge_p     out  1       o_px >= p
//   o_y_ge_p     out  1       o_py >= p
// ---------------------------------------------------------------------------
module ed25519_in_unpack #(
    parameter int DATA_W = 64,
    parameter int PATN_W = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_pkt_valid,
    input  logic              i_pkt_ready,
    output logic [PATN_W-1:0] o_scalar,
    output logic [PATN_W-1:0] o_px,
    output logic [PATN_W-1:0] o_py,
    output logic              o_x_ge_p,
    output logic              o_y_ge_p
);

    localparam int NBEATS = 3 * PATN_W / DATA_W;
    localparam int PKT_W  = 3 * PATN_W;
    localparam logic [3:0] LAST_BEAT = 4'(NBEATS - 1);

    // p = 2^255 - 19 = 0x7FFF...FFED
    localparam logic [PATN_W-1:0] P_MOD =
        {{(PATN_W - 255){1'b0}}, {250{1'b1}}, 5'b01101};

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               live_q;     // low during reset and for the first edge after it
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic               x_ge_q, x_ge_d;
    logic               y_ge_q, y_ge_d;
    logic               xfer;

    // Beats shift in at the bottom. After NBEATS transfers, beat 0 sits in
    // the top word of the scalar and the last beat is the bottom word of y.
    // A gap simply stalls the shift, so gaps cannot misplace words.
    assign o_in_ready  = live_q && (state_q == COLLECT);
    assign o_pkt_valid = (state_q == HOLD);
    assign xfer        = i_in_valid && o_in_ready;

    assign o_scalar = pkt_q[PKT_W-1 -: PATN_W];
    assign o_px     = pkt_q[2*PATN_W-1 -: PATN_W];
    assign o_py     = pkt_q[PATN_W-1:0];
    assign o_x_ge_p = x_ge_q;
    assign o_y_ge_p = y_ge_q;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pkt_d   = pkt_q;
        x_ge_d  = x_ge_q;
        y_ge_d  = y_ge_q;

        case (state_q)
            COLLECT: begin
                if (xfer) begin
                    // NOTE: blocking assignments in combinational logic. This
                    // lets the compare below see the shifted value
                    // immediately. Registers use non-blocking assignments.
                    pkt_d = {pkt_q[PKT_W-DATA_W-1:0], i_in_data};
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                        // Compare the complete operands, including the beat
                        // that arrives on this edge.
                        x_ge_d  = (pkt_d[2*PATN_W-1 -: PATN_W] >= P_MOD);
                        y_ge_d  = (pkt_d[PATN_W-1:0] >= P_MOD);
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                // Input is ignored here. Operands stay frozen until accepted.
                if (i_pkt_ready) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: the operand storage is reset as well. Outputs must read zero
    // during reset, and the asynchronous clear also drops any partial or
    // pending packet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            pkt_q   <= '0;
            x_ge_q  <= 1'b0;
            y_ge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            pkt_q   <= pkt_d;
            x_ge_q  <= x_ge_d;
            y_ge_q  <= y_ge_d;
        end
    end

endmodule

// File: tb/tb_ed25519_in_unpack.sv
// ---------------------------------------------------------------------------
// tb_ed25519_in_unpack
//
// Directed and random stimulus for ed25519_in_unpack. A transaction-level
// model keeps a queue of pending input words and a queue of expected
// packets. It predicts ready/valid each cycle and the operands and range
// flags of each completed packet.
// ---------------------------------------------------------------------------
module tb_ed25519_in_unpack;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [63:0]  i_in_data = '0;
    logic         o_pkt_valid;
    logic         i_pkt_ready = 1'b0;
    logic [255:0] o_scalar, o_px, o_py;
    logic         o_x_ge_p, o_y_ge_p;

    ed25519_in_unpack #(.DATA_W(64), .PATN_W(256)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .o_pkt_valid (o_pkt_valid),
        .i_pkt_ready (i_pkt_ready),
        .o_scalar    (o_scalar),
        .o_px        (o_px),
        .o_py        (o_py),
        .o_x_ge_p    (o_x_ge_p),
        .o_y_ge_p    (o_y_ge_p)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [255:0] s;
        logic [255:0] x;
        logic [255:0] y;
    } pkt_t;

    localparam logic [255:0] ALL1 = {256{1'b1}};

    logic [255:0] p_mod;
    logic [63:0]  src_q[$];   // words still to be offered upstream
    pkt_t         exp_q[$];   // packets expected, in order

    // model state
    bit   m_fresh, m_ready, m_valid;
    int   m_nb;
    pkt_t m_pkt;
    bit   m_xf, m_yf;
    int   hs;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_pkt(input logic [255:0] s, input logic [255:0] x, input logic [255:0] y);
        pkt_t p;
        logic [255:0] ops[3];
        p.s = s; p.x = x; p.y = y;
        exp_q.push_back(p);
        ops[0] = s; ops[1] = x; ops[2] = y;
        for (int o = 0; o < 3; o++)
            for (int w = 0; w < 4; w++)
                src_q.push_back(ops[o][255 - 64*w -: 64]);
    endtask

    // One clock cycle: drive, advance model on the edge, check #1 later.
    task automatic step(input bit v, input bit r);
        bit vv;
        vv = v && (src_q.size() > 0);
        i_in_valid  = vv;
        i_in_data   = vv ? src_q[0] : {$urandom, $urandom};
        i_pkt_ready = r;
        @(posedge i_clk);
        if (m_fresh) begin
            m_fresh = 1'b0;
            m_ready = 1'b1;
        end else if (m_valid) begin
            if (r) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
                hs++;
            end
        end else if (m_ready && vv) begin
            void'(src_q.pop_front());
            m_nb++;
            if (m_nb == 12) begin
                m_nb    = 0;
                m_valid = 1'b1;
                m_ready = 1'b0;
                if (exp_q.size() > 0) m_pkt = exp_q.pop_front();
                m_xf = (m_pkt.x >= p_mod);
                m_yf = (m_pkt.y >= p_mod);
            end
        end
        #1;
        check("in_ready", o_in_ready, m_ready);
        check("pkt_valid", o_pkt_valid, m_valid);
        if (m_valid) begin
            check("scalar", o_scalar, m_pkt.s);
            check("px", o_px, m_pkt.x);
            check("py", o_py, m_pkt.y);
            check("x_ge_p", o_x_ge_p, m_xf);
            check("y_ge_p", o_y_ge_p, m_yf);
        end
    endtask

    task automatic do_reset();
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_in_ready", o_in_ready, 0);
        check("rst_pkt_valid", o_pkt_valid, 0);
        check("rst_scalar", o_scalar, 0);
        check("rst_px", o_px, 0);
        check("rst_py", o_py, 0);
        check("rst_x_ge_p", o_x_ge_p, 0);
        check("rst_y_ge_p", o_y_ge_p, 0);
        src_q.delete();
        exp_q.delete();
        m_ready = 1'b0;
        m_valid = 1'b0;
        m_nb    = 0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_hold_ready", o_in_ready, 0);
        i_rst_n = 1'b1;
        m_fresh = 1'b1;
    endtask

    initial begin
        int n;
        int cyc;
        p_mod = (256'd1 << 255) - 256'd19;
        hs = 0;

        // Power-on reset; first packet offered on the very first edge.
        do_reset();
        push_pkt({4{64'h0101010101010101}}, {4{64'h2222222222222222}},
                 {4{64'h3333333333333333}});
        push_pkt(rnd256(), rnd256(), rnd256());
        repeat (27) step(1'b1, 1'b1);
        check("b2b_drained", 256'(src_q.size()), 0);

        // Range edges of the canonical-value flags.
        push_pkt(rnd256(), p_mod - 256'd1, p_mod);
        push_pkt(rnd256(), p_mod, ALL1);
        push_pkt(rnd256(), 256'd0, 256'd0);
        push_pkt(rnd256(), ALL1, p_mod - 256'd1);
        repeat (52) step(1'b1, 1'b1);

        // Long stall in HOLD while upstream keeps offering data.
        push_pkt(rnd256(), rnd256(), rnd256());
        push_pkt(rnd256(), rnd256(), rnd256());
        n = 0;
        while (!m_valid && n < 40) begin
            step(1'b1, 1'b0);
            n++;
        end
        repeat (50) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (13) step(1'b1, 1'b1);

        // Reset after six accepted beats (beats 0..5), then a fresh packet.
        push_pkt(rnd256(), rnd256(), rnd256());
        repeat (6) step(1'b1, 1'b1);
        do_reset();
        push_pkt(rnd256(), rnd256(), rnd256());
        repeat (14) step(1'b1, 1'b1);

        // Reset while a packet is pending in HOLD.
        push_pkt(rnd256(), rnd256(), rnd256());
        repeat (15) step(1'b1, 1'b0);
        do_reset();
        push_pkt(rnd256(), rnd256(), rnd256());
        repeat (14) step(1'b1, 1'b1);

        // Random valid/ready over 200 packets.
        for (int i = 0; i < 200; i++) push_pkt(rnd256(), rnd256(), rnd256());
        hs  = 0;
        cyc = 0;
        while (hs < 200 && cyc < 20000) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc++;
        end
        check("random_done", 256'(hs), 256'd200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ed25519_in_unpack.md
ED25519_IN_UNPACK -- requirements
Module: ed25519_in_unpack

Interface
REQ-001 Parameter DATA_W, default 64, width of one input beat in bits.
REQ-002 Parameter PATN_W, default 256, width of one operand; beats per operand = PATN_W/DATA_W = 4.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_in_valid  input  1  upstream beat valid.
REQ-006 o_in_ready  output  1  block can accept a beat.
REQ-007 i_in_data  input  DATA_W  input beat.
REQ-008 o_pkt_valid  output  1  assembled packet valid to ed25519 core.
REQ-009 i_pkt_ready  input  1  core accepts packet.
REQ-010 o_scalar  output  PATN_W  scalar k.
REQ-011 o_px  output  PATN_W  base point x.
REQ-012 o_py  output  PATN_W  base point y.
REQ-013 o_x_ge_p  output  1  o_px >= p, p = 2^255-19.
REQ-014 o_y_ge_p  output  1  o_py >= p.

Function
REQ-015 A beat SHALL transfer only on a rising edge where i_in_valid=1 and o_in_ready=1; no other edge changes the beat counter.
REQ-016 Packet = 12 beats in order: scalar, x, y; each operand most-significant word first (beat 0 -> o_scalar[255:192], beat 3 -> o_scalar[63:0], beat 4 -> o_px[255:192], beat 11 -> o_py[63:0]).
REQ-017 FSM states: COLLECT, HOLD. COLLECT: o_in_ready=1, o_pkt_valid=0. HOLD: o_in_ready=0, o_pkt_valid=1.
REQ-018 Beat counter 4 bits, 0..11; increments on each transfer; transfer with counter=11 SHALL set counter to 0 and move to HOLD on that same edge.
REQ-019 o_pkt_valid SHALL assert the cycle immediately after the 12th transfer (latency 1 cycle from last beat edge).
REQ-020 HOLD: outputs o_scalar/o_px/o_py/o_x_ge_p/o_y_ge_p SHALL remain stable until handshake; i_in_valid ignored.
REQ-021 Edge with o_pkt_valid=1 and i_pkt_ready=1 SHALL return to COLLECT; o_in_ready=1 next cycle; no beat accepted on the handshake edge.
REQ-022 o_pkt_valid SHALL not deassert before handshake regardless of i_pkt_ready toggling.
REQ-023 o_x_ge_p/o_y_ge_p SHALL be registered, updated on the edge entering HOLD from the complete operand values (unsigned 256-bit compare against 0x7FFF...FFED), valid whenever o_pkt_valid=1.
REQ-024 Operand registers SHALL not be cleared on handshake; partially overwritten during next packet collection (contents undefined while o_pkt_valid=0).
REQ-025 Gaps (i_in_valid low) of any length between beats SHALL not corrupt word placement.
REQ-026 Sustained throughput: 12 input cycles + 1 handshake cycle per packet when both sides always ready.

Reset
REQ-027 i_rst_n=0 SHALL immediately (asynchronously) force state COLLECT, counter 0, o_in_ready=0, o_pkt_valid=0, o_x_ge_p=0, o_y_ge_p=0, o_scalar/o_px/o_py=0.
REQ-028 o_in_ready SHALL rise on the first rising edge after i_rst_n deasserts; no beat accepted on that edge.
REQ-029 Reset mid-collection or in HOLD SHALL discard the partial/pending packet; next packet restarts at beat 0.

Verification
REQ-030 Back-to-back: 12 beats, scalar=0x01..., x=0x2..., y=0x3... words, i_pkt_ready=1 -> o_pkt_valid high 1 cycle after beat 11, exact operand match, o_x_ge_p=o_y_ge_p=0.
REQ-031 Random i_in_valid/i_pkt_ready (50%) over 200 packets -> all packets match model; no beat accepted in HOLD; o_pkt_valid never drops before handshake.
REQ-032 Range edges: x=p-1 -> o_x_ge_p=0; x=p -> 1; y=2^256-1 -> o_y_ge_p=1; x=0 -> 0.
REQ-033 Reset after beat 5 then full 12-beat packet -> output equals second packet only, beat 0 to o_scalar[255:192].
REQ-034 i_pkt_ready held 0 for 50 cycles in HOLD, i_in_valid=1 -> o_in_ready=0, outputs unchanged, then handshake -> o_in_ready=1 next cycle.
